// File: rtl/pipelined_controller_hz.sv
// Decode-stage control unit with integrated hazard unit for the 5-stage MIPS pipeline.
// Decodes op/funct in D and carries the control bits through the D/X, X/M and M/W
// registers. It also generates load-use and branch stalls, forwarding selects, a
// bubble into X, the taken-branch/jump squash of F/D and a saturating stall counter.
// Ports:
//   clk, reset                     clock, async active-high reset
//   op, funct, equal_d             D-stage instruction fields and register compare
//   rs_d, rt_d, rs_x, rt_x         source register numbers in D and X
//   write_reg_x/_m/_w              destination register numbers in X, M and W
//   pc_src_d, jump_d               taken branch / jump (combinational)
//   flush_d, flush_x               clear F/D / bubble into X (combinational)
//   stall_f, stall_d               hold PC / hold F/D (combinational)
//   forward_a_d, forward_b_d       M result to the D compare (combinational)
//   forward_a_x, forward_b_x       10=M, 01=W, 00=register file (combinational)
//   alu_src_x, reg_dest_x,
//   zero_ext_x, alu_ctrl_x         X-stage controls (registered)
//   dmem_write_m                   store enable (registered)
//   reg_write_w, mem_to_reg_w      writeback controls (registered)
//   stall_cnt                      saturating count of stall cycles (registered)
module pipelined_controller_hz #(
  parameter int unsigned ALU_CTRL_W = 3,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned DELAY_SLOT = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            op,
  input  logic [5:0]            funct,
  input  logic                  equal_d,
  input  logic [REG_ADDR_W-1:0] rs_d,
  input  logic [REG_ADDR_W-1:0] rt_d,
  input  logic [REG_ADDR_W-1:0] rs_x,
  input  logic [REG_ADDR_W-1:0] rt_x,
  input  logic [REG_ADDR_W-1:0] write_reg_x,
  input  logic [REG_ADDR_W-1:0] write_reg_m,
  input  logic [REG_ADDR_W-1:0] write_reg_w,
  output logic                  pc_src_d,
  output logic                  jump_d,
  output logic                  flush_d,
  output logic                  flush_x,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  alu_src_x,
  output logic                  reg_dest_x,
  output logic                  zero_ext_x,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_x,
  output logic                  forward_a_d,
  output logic                  forward_b_d,
  output logic [1:0]            forward_a_x,
  output logic [1:0]            forward_b_x,
  output logic                  dmem_write_m,
  output logic                  reg_write_w,
  output logic                  mem_to_reg_w,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // D-stage decoded controls
  logic       reg_write_d, mem_to_reg_d, dmem_write_d;
  logic       alu_src_d, reg_dest_d, zero_ext_d;
  logic [2:0] alu_code_d;
  logic       branch_d, is_bne_d, is_jump_d;
  logic       uses_rs_d, uses_rt_d;

  // Pipeline control bits not visible at the ports
  logic reg_write_x, mem_to_reg_x, dmem_write_x;
  logic reg_write_m, mem_to_reg_m;

  logic lw_stall, br_stall, stall;

  // Main decoder; anything unrecognised stays at the all-zero NOP defaults
  always_comb begin
    reg_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    dmem_write_d = 1'b0;
    alu_src_d    = 1'b0;
    reg_dest_d   = 1'b0;
    zero_ext_d   = 1'b0;
    alu_code_d   = ALU_AND;
    branch_d     = 1'b0;
    is_bne_d     = 1'b0;
    is_jump_d    = 1'b0;
    uses_rs_d    = 1'b0;
    uses_rt_d    = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          6'b100000: alu_code_d = ALU_ADD;
          6'b100010: alu_code_d = ALU_SUB;
          6'b100100: alu_code_d = ALU_AND;
          6'b100101: alu_code_d = ALU_OR;
          6'b101010: alu_code_d = ALU_SLT;
          default:   alu_code_d = ALU_AND;
        endcase
        if (funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) begin
          reg_write_d = 1'b1;
          reg_dest_d  = 1'b1;
          uses_rs_d   = 1'b1;
          uses_rt_d   = 1'b1;
        end
      end
      OP_LW: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = 1'b1;
        alu_src_d    = 1'b1;
        alu_code_d   = ALU_ADD;
        uses_rs_d    = 1'b1;
      end
      OP_SW: begin
        dmem_write_d = 1'b1;
        alu_src_d    = 1'b1;
        alu_code_d   = ALU_ADD;
        uses_rs_d    = 1'b1;
        uses_rt_d    = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        branch_d   = 1'b1;
        is_bne_d   = (op == OP_BNE);
        alu_code_d = ALU_SUB;
        uses_rs_d  = 1'b1;
        uses_rt_d  = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        uses_rs_d   = 1'b1;
        zero_ext_d  = (op == OP_ANDI) || (op == OP_ORI);
        case (op)
          OP_ANDI: alu_code_d = ALU_AND;
          OP_ORI:  alu_code_d = ALU_OR;
          OP_SLTI: alu_code_d = ALU_SLT;
          default: alu_code_d = ALU_ADD;
        endcase
      end
      OP_J:    is_jump_d = 1'b1;
      default: ;
    endcase
  end

  // Hazard detection: only sources the instruction actually reads can stall
  assign lw_stall = mem_to_reg_x & ((uses_rs_d & (rt_x == rs_d)) |
                                    (uses_rt_d & (rt_x == rt_d)));
  assign br_stall = branch_d &
                    ((reg_write_x  & ((rs_d == write_reg_x) | (rt_d == write_reg_x))) |
                     (mem_to_reg_m & ((rs_d == write_reg_m) | (rt_d == write_reg_m))));
  assign stall    = lw_stall | br_stall;

  assign stall_f  = stall;
  assign stall_d  = stall;
  assign flush_x  = stall;
  assign pc_src_d = branch_d & (equal_d ^ is_bne_d) & ~stall;
  assign jump_d   = is_jump_d & ~stall;
  // With a delay slot the instruction behind a branch/jump executes, so F/D is never cleared
  assign flush_d  = (DELAY_SLOT == 0) ? ((pc_src_d | jump_d) & ~stall) : 1'b0;

  // Forwarding; register 0 is hard-wired and never forwarded
  assign forward_a_d = reg_write_m & (rs_d != '0) & (rs_d == write_reg_m);
  assign forward_b_d = reg_write_m & (rt_d != '0) & (rt_d == write_reg_m);

  always_comb begin
    forward_a_x = 2'b00;
    forward_b_x = 2'b00;
    if (rs_x != '0) begin
      if (reg_write_m && (rs_x == write_reg_m))      forward_a_x = 2'b10;
      else if (reg_write_w && (rs_x == write_reg_w)) forward_a_x = 2'b01;
    end
    if (rt_x != '0) begin
      if (reg_write_m && (rt_x == write_reg_m))      forward_b_x = 2'b10;
      else if (reg_write_w && (rt_x == write_reg_w)) forward_b_x = 2'b01;
    end
  end

  // D/X register: bubble when the hazard unit flushes X
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_x  <= 1'b0;
      mem_to_reg_x <= 1'b0;
      dmem_write_x <= 1'b0;
      alu_src_x    <= 1'b0;
      reg_dest_x   <= 1'b0;
      zero_ext_x   <= 1'b0;
      alu_ctrl_x   <= '0;
    end else if (flush_x) begin
      reg_write_x  <= 1'b0;
      mem_to_reg_x <= 1'b0;
      dmem_write_x <= 1'b0;
      alu_src_x    <= 1'b0;
      reg_dest_x   <= 1'b0;
      zero_ext_x   <= 1'b0;
      alu_ctrl_x   <= '0;
    end else begin
      reg_write_x  <= reg_write_d;
      mem_to_reg_x <= mem_to_reg_d;
      dmem_write_x <= dmem_write_d;
      alu_src_x    <= alu_src_d;
      reg_dest_x   <= reg_dest_d;
      zero_ext_x   <= zero_ext_d;
      alu_ctrl_x   <= ALU_CTRL_W'(alu_code_d);
    end
  end

  // X/M and M/W registers always advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_m  <= 1'b0;
      mem_to_reg_m <= 1'b0;
      dmem_write_m <= 1'b0;
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
    end else begin
      reg_write_m  <= reg_write_x;
      mem_to_reg_m <= mem_to_reg_x;
      dmem_write_m <= dmem_write_x;
      reg_write_w  <= reg_write_m;
      mem_to_reg_w <= mem_to_reg_m;
    end
  end

  // Stall cycle counter, holds at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
